pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
- Consumes the single-bit hazard flag from the hazard-detection stage and the EX-stage branch-resolution signal.
- Drives the pipeline steering signals: PC write enable, IF/ID hold, IF/ID flush and ID/EX control flush.
- Small FSM (RUN/STALL/FLUSH). Suppresses false hazards for the cycle after a flush, because a flushed IF/ID bubble carries register-0 fields.
- Keeps saturating stall/flush performance counters and a sticky stall-timeout error flag.

Parameters:
- MAX_STALL, 4, consecutive stall cycles after which stall_timeout is set (legal range 2..15).
- CNT_W, 16, width of the performance counters.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- hasHazard  input  1  data hazard flag from hazard detection, valid each cycle.
- branch_taken  input  1  branch/jump resolved taken in EX this cycle.
- PCWrite  output  1  PC update enable.
- IF_ID_Hold  output  1  IF/ID register keeps its current contents.
- IF_ID_Flush  output  1  IF/ID register loads a bubble (all zeros).
- ID_EX_CtrlFlush  output  1  ID/EX control fields forced to zero (bubble inserted).
- stall_timeout  output  1  sticky flag: a stall lasted MAX_STALL or more consecutive cycles.
- stall_count  output  CNT_W  total stall cycles, saturating.
- flush_count  output  CNT_W  total branch-flush cycles, saturating.

Behaviour:
- Clocking: one clock; reset is asynchronous and active-high.
- Registered state: state, run_len (4 bits), stall_timeout, stall_count, flush_count.
- On reset assertion, immediately: state=RUN, run_len=0, stall_timeout=0, counters=0.
- Output values while reset is high: PCWrite=0, IF_ID_Hold=0, IF_ID_Flush=1, ID_EX_CtrlFlush=1.
- Steering outputs are combinational from state, hasHazard and branch_taken. Zero latency: they act in the same cycle as the inputs.
- Priority is fixed: branch_taken > hasHazard > normal. Branch is resolved in EX, so an instruction stalled in ID is younger than the branch and is discarded.
- Flush cycle (branch_taken=1, any state):
  - Outputs: PCWrite=1 (redirect), IF_ID_Flush=1, ID_EX_CtrlFlush=1, IF_ID_Hold=0.
  - Next state FLUSH; run_len cleared; flush_count+1.
- Stall cycle (branch_taken=0, hasHazard=1, state RUN or STALL):
  - Outputs: PCWrite=0, IF_ID_Hold=1, ID_EX_CtrlFlush=1, IF_ID_Flush=0.
  - Next state STALL; stall_count+1; run_len+1, saturating at 15.
  - If the incremented run_len >= MAX_STALL, set stall_timeout at the same edge.
- Normal cycle:
  - Outputs: PCWrite=1, IF_ID_Hold=0, IF_ID_Flush=0, ID_EX_CtrlFlush=0.
  - Next state RUN; run_len cleared.
- FLUSH state:
  - hasHazard is ignored for exactly one cycle; that cycle is a normal cycle unless branch_taken=1.
  - branch_taken=1 in FLUSH gives another flush cycle and the FSM stays in FLUSH.
- STALL with hasHazard=0 and branch_taken=0: normal cycle, return to RUN.
- Timeout handling: stall_timeout is sticky until reset. It does not change steering; the controller keeps stalling as long as hasHazard=1.
- Counters saturate at 2^CNT_W-1 and never wrap.
- IF_ID_Hold and IF_ID_Flush are never both 1. PCWrite=0 only in stall cycles and during reset.
- Reset mid-stall or mid-flush: asynchronous return to RUN; outputs take their reset values immediately.

Test Plan:
1. Reset release, hasHazard=0, branch_taken=0 for 5 cycles -> PCWrite=1 and all other steering signals 0 every cycle; counters stay 0; state RUN.
2. hasHazard=1 for 2 cycles, then 0 -> 2 cycles with PCWrite=0, IF_ID_Hold=1, ID_EX_CtrlFlush=1; then normal; stall_count=2; stall_timeout=0.
3. hasHazard=1 together with branch_taken=1 in the same cycle -> flush outputs (PCWrite=1, IF_ID_Flush=1, ID_EX_CtrlFlush=1, Hold=0); next cycle hasHazard=1 is ignored (normal outputs); flush_count=1, stall_count=0.
4. hasHazard held high for 6 cycles with MAX_STALL=4 -> stall_timeout rises at the 4th stall edge and stays 1 after hasHazard drops; stall_count=6; stalling continues through all 6 cycles.
5. branch_taken high 2 consecutive cycles -> two flush cycles, FSM stays in FLUSH, then one hazard-ignored cycle; flush_count=2.
6. Reset asserted mid-stall (hasHazard=1) -> outputs go to PCWrite=0, Flush=1, CtrlFlush=1 before the next clock edge; all counters and stall_timeout read 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Turns the hazard-detection flag and the EX-stage branch resolution into the
// pipeline steering signals. A small RUN/STALL/FLUSH FSM sits underneath.
// Branches take priority over data hazards because the branch is resolved in
// EX, so any instruction stalled in ID is younger and gets discarded anyway.
// For the cycle after a flush the hazard flag is ignored: the bubble in IF/ID
// carries register-0 fields and can raise a false hazard.
//
// Steering outputs are combinational (zero latency). There is no valid/ready
// handshake here; every input is sampled every cycle.
//
// Ports
//   clock            in   system clock, rising edge
//   reset            in   asynchronous, active-high reset
//   hasHazard        in   data hazard flag from hazard detection
//   branch_taken     in   branch/jump resolved taken in EX this cycle
//   PCWrite          out  PC update enable
//   IF_ID_Hold       out  IF/ID keeps its contents
//   IF_ID_Flush      out  IF/ID loads a bubble
//   ID_EX_CtrlFlush  out  ID/EX control fields forced to zero
//   stall_timeout    out  sticky: a stall lasted MAX_STALL+ consecutive cycles
//   stall_count      out  total stall cycles, saturating
//   flush_count      out  total branch-flush cycles, saturating
//   state_dbg        out  current FSM state (RUN=0, STALL=1, FLUSH=2)
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl #(
    parameter int MAX_STALL = 4,   // legal range 2..15
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hasHazard,
    input  logic             branch_taken,
    output logic             PCWrite,
    output logic             IF_ID_Hold,
    output logic             IF_ID_Flush,
    output logic             ID_EX_CtrlFlush,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam logic [3:0]       MAX_STALL_L = 4'(MAX_STALL);
    localparam logic [3:0]       RUN_LEN_MAX = 4'hF;
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    logic [1:0] state;
    logic [3:0] run_len;
    logic [3:0] run_len_inc;
    logic       flush_cyc;
    logic       stall_cyc;

    assign state_dbg = state;

    // Cycle classification. In FLUSH the hazard flag is masked for one cycle.
    assign flush_cyc   = branch_taken;
    assign stall_cyc   = !branch_taken && hasHazard && (state != FLUSH);
    assign run_len_inc = (run_len == RUN_LEN_MAX) ? RUN_LEN_MAX : run_len + 4'd1;

    // Steering. While reset is high the pipeline is held in a bubbling state
    // with the PC frozen.
    always_comb begin
        PCWrite         = 1'b1;
        IF_ID_Hold      = 1'b0;
        IF_ID_Flush     = 1'b0;
        ID_EX_CtrlFlush = 1'b0;
        if (reset) begin
            PCWrite         = 1'b0;
            IF_ID_Flush     = 1'b1;
            ID_EX_CtrlFlush = 1'b1;
        end else if (flush_cyc) begin
            PCWrite         = 1'b1;
            IF_ID_Flush     = 1'b1;
            ID_EX_CtrlFlush = 1'b1;
        end else if (stall_cyc) begin
            PCWrite         = 1'b0;
            IF_ID_Hold      = 1'b1;
            ID_EX_CtrlFlush = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= RUN;
            run_len       <= 4'd0;
            stall_timeout <= 1'b0;
            stall_count   <= '0;
            flush_count   <= '0;
        end else if (flush_cyc) begin
            state   <= FLUSH;
            run_len <= 4'd0;
            if (flush_count != CNT_MAX) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end else if (stall_cyc) begin
            state   <= STALL;
            run_len <= run_len_inc;
            if (stall_count != CNT_MAX) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            // Timeout is sticky; it never alters steering.
            if (run_len_inc >= MAX_STALL_L) begin
                stall_timeout <= 1'b1;
            end
        end else begin
            state   <= RUN;
            run_len <= 4'd0;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

  localparam int MAX_STALL = 4;
  localparam int CNT_W     = 4;   // small width so saturation is reachable

  // Expected steering vectors {PCWrite, IF_ID_Hold, IF_ID_Flush, ID_EX_CtrlFlush}
  localparam logic [3:0] NORM_V  = 4'b1000;
  localparam logic [3:0] STALL_V = 4'b0101;
  localparam logic [3:0] FLUSH_V = 4'b1011;
  localparam logic [3:0] RST_V   = 4'b0011;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic             clock;
  logic             reset;
  logic             hasHazard;
  logic             branch_taken;
  logic             PCWrite;
  logic             IF_ID_Hold;
  logic             IF_ID_Flush;
  logic             ID_EX_CtrlFlush;
  logic             stall_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic [1:0]       state_dbg;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  pipeline_stall_ctrl #(
    .MAX_STALL(MAX_STALL),
    .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .hasHazard(hasHazard),
    .branch_taken(branch_taken),
    .PCWrite(PCWrite),
    .IF_ID_Hold(IF_ID_Hold),
    .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_CtrlFlush(ID_EX_CtrlFlush),
    .stall_timeout(stall_timeout),
    .stall_count(stall_count),
    .flush_count(flush_count),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // One pipeline cycle: drive inputs at negedge, push the expected steering
  // vector, pop and compare it before the rising edge, then step past the edge.
  task automatic cycle(input logic hz, input logic br, input logic [3:0] exp_v,
                       input string name);
    logic [3:0] obs;
    logic [3:0] e;
    @(negedge clock);
    hasHazard    = hz;
    branch_taken = br;
    exp_q.push_back(exp_v);
    #1;
    obs = {PCWrite, IF_ID_Hold, IF_ID_Flush, ID_EX_CtrlFlush};
    e   = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL %s steer got %b exp %b", name, obs, e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_regs(input string name, input int sc, input int fc,
                            input logic to, input logic [1:0] st);
    checks++;
    if (stall_count !== CNT_W'(sc)) begin
      errors++;
      $display("FAIL %s stall_count got %0d exp %0d", name, stall_count, sc);
    end
    checks++;
    if (flush_count !== CNT_W'(fc)) begin
      errors++;
      $display("FAIL %s flush_count got %0d exp %0d", name, flush_count, fc);
    end
    checks++;
    if (stall_timeout !== to) begin
      errors++;
      $display("FAIL %s stall_timeout got %b exp %b", name, stall_timeout, to);
    end
    checks++;
    if (state_dbg !== st) begin
      errors++;
      $display("FAIL %s state got %0d exp %0d", name, state_dbg, st);
    end
  endtask

  task automatic check_reset_steer(input string name);
    logic [3:0] obs;
    obs = {PCWrite, IF_ID_Hold, IF_ID_Flush, ID_EX_CtrlFlush};
    checks++;
    if (obs !== RST_V) begin
      errors++;
      $display("FAIL %s steer got %b exp %b", name, obs, RST_V);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset        = 1'b1;
    hasHazard    = 1'b0;
    branch_taken = 1'b0;
    #1;
    check_reset_steer("do_reset");
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset        = 1'b1;
    hasHazard    = 1'b0;
    branch_taken = 1'b0;
    #2;
    check_reset_steer("reset_hold");
    check_regs("reset_hold", 0, 0, 1'b0, S_RUN);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, NORM_V, "reset_run");
      check_regs("reset_run", 0, 0, 1'b0, S_RUN);
    end
  endtask

  task automatic test_stall();
    do_reset();
    cycle(1'b1, 1'b0, STALL_V, "stall_1");
    cycle(1'b1, 1'b0, STALL_V, "stall_2");
    check_regs("stall_2", 2, 0, 1'b0, S_STALL);
    cycle(1'b0, 1'b0, NORM_V, "stall_end");
    check_regs("stall_end", 2, 0, 1'b0, S_RUN);
  endtask

  task automatic test_branch_priority();
    do_reset();
    cycle(1'b1, 1'b1, FLUSH_V, "prio_flush");
    check_regs("prio_flush", 0, 1, 1'b0, S_FLUSH);
    cycle(1'b1, 1'b0, NORM_V, "prio_masked");
    check_regs("prio_masked", 0, 1, 1'b0, S_RUN);
    // Mask lasts exactly one cycle.
    cycle(1'b1, 1'b0, STALL_V, "prio_after");
    check_regs("prio_after", 1, 1, 1'b0, S_STALL);
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b1, 1'b0, STALL_V, "timeout_stall");
      check_regs("timeout_stall", i, 0, (i >= MAX_STALL), S_STALL);
    end
    cycle(1'b0, 1'b0, NORM_V, "timeout_release");
    check_regs("timeout_release", 6, 0, 1'b1, S_RUN);
    cycle(1'b0, 1'b0, NORM_V, "timeout_sticky");
    check_regs("timeout_sticky", 6, 0, 1'b1, S_RUN);
  endtask

  task automatic test_back_to_back();
    do_reset();
    // Stall of MAX_STALL-1 cycles must not time out.
    for (int i = 1; i < MAX_STALL; i++) cycle(1'b1, 1'b0, STALL_V, "b2b_short");
    check_regs("b2b_short", MAX_STALL - 1, 0, 1'b0, S_STALL);
    // Branch interrupting a stall wins and clears run length.
    cycle(1'b1, 1'b1, FLUSH_V, "b2b_flush1");
    cycle(1'b0, 1'b1, FLUSH_V, "b2b_flush2");
    check_regs("b2b_flush2", MAX_STALL - 1, 2, 1'b0, S_FLUSH);
    cycle(1'b1, 1'b0, NORM_V, "b2b_masked");
    cycle(1'b1, 1'b0, STALL_V, "b2b_restall");
    check_regs("b2b_restall", MAX_STALL, 2, 1'b0, S_STALL);
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    cycle(1'b1, 1'b0, STALL_V, "mid_stall1");
    cycle(1'b1, 1'b1, FLUSH_V, "mid_flush");
    cycle(1'b0, 1'b1, FLUSH_V, "mid_flush2");
    cycle(1'b1, 1'b0, NORM_V, "mid_masked");
    cycle(1'b1, 1'b0, STALL_V, "mid_stall2");
    // Assert reset between edges with hazard still high.
    hasHazard = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_reset_steer("mid_reset");
    check_regs("mid_reset", 0, 0, 1'b0, S_RUN);
    @(negedge clock);
    reset     = 1'b0;
    hasHazard = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, STALL_V, "sat_stall");
    check_regs("sat_stall", 15, 0, 1'b1, S_STALL);
    for (int i = 0; i < 18; i++) cycle(1'b0, 1'b1, FLUSH_V, "sat_flush");
    check_regs("sat_flush", 15, 15, 1'b1, S_FLUSH);
  endtask

  task automatic test_random();
    logic [1:0] mst;
    int         mrun;
    int         msc;
    int         mfc;
    logic       mto;
    logic       hz;
    logic       br;
    logic [3:0] ev;
    do_reset();
    mst = S_RUN; mrun = 0; msc = 0; mfc = 0; mto = 1'b0;
    for (int i = 0; i < 80; i++) begin
      hz = 1'($urandom_range(0, 1));
      br = ($urandom_range(0, 3) == 0);
      if (br) begin
        ev = FLUSH_V; mst = S_FLUSH; mrun = 0;
        if (mfc < 15) mfc++;
      end else if (hz && mst != S_FLUSH) begin
        ev = STALL_V; mst = S_STALL;
        if (mrun < 15) mrun++;
        if (msc < 15) msc++;
        if (mrun >= MAX_STALL) mto = 1'b1;
      end else begin
        ev = NORM_V; mst = S_RUN; mrun = 0;
      end
      cycle(hz, br, ev, "random");
      check_regs("random", msc, mfc, mto, mst);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_stall();
    test_branch_priority();
    test_timeout();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
